// File: rtl/spi_word_slave.sv
// SPI mode-0 word slave: deserialises master writes into rx_data, serialises a held word on reads.
// Define SPI_SLAVE_OVERRUN_EN to build the sticky receive-overrun flag; otherwise overrun reads 0.
`timescale 1ns/1ps
module spi_word_slave #(
    parameter int BUS_WIDTH    = 32,
    parameter int WORD_SIZE_BY = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sck,
    input  logic                 cs,
    input  logic                 mosi,
    output logic                 miso,
    input  logic                 rw,
    output logic                 intr,
    output logic [BUS_WIDTH-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    input  logic [BUS_WIDTH-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 busy,
    output logic                 overrun
);
    localparam int BYTE_W = (WORD_SIZE_BY > 1) ? $clog2(WORD_SIZE_BY) : 1;
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(WORD_SIZE_BY - 1);

    typedef enum logic [1:0] {
        IDLE,
        RX_FRAME,
        TX_FRAME
    } state_t;

    state_t               state;
    logic [2:0]           sck_sync;
    logic [2:0]           cs_sync;
    logic [1:0]           mosi_sync;
    logic [2:0]           bit_cnt;
    logic [BYTE_W-1:0]    byte_cnt;
    logic [2:0]           bit_next;
    logic [BYTE_W-1:0]    byte_next;
    logic [BUS_WIDTH-2:0] rx_shift;
    logic [BUS_WIDTH-1:0] tx_shift;
    logic [BUS_WIDTH-1:0] hold_data;
    logic                 hold_full;
    logic                 mosi_bit;
    logic                 sck_rise;
    logic                 sck_fall;
    logic                 cs_rise;
    logic                 cs_fall;
    logic                 word_end;
    logic                 rx_word_done;
    logic                 tx_word_end;
    logic                 tx_enter;
    logic                 reload;
    logic                 tx_capture;
    logic [BUS_WIDTH-1:0] reload_word;

    // Index 1 is the synchronised level; index 2 is one clk older, used for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync  <= 3'b000;
            cs_sync   <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            sck_sync  <= {sck_sync[1:0], sck};
            cs_sync   <= {cs_sync[1:0], cs};
            mosi_sync <= {mosi_sync[0], mosi};
        end
    end

    assign mosi_bit = mosi_sync[1];
    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign sck_fall = ~sck_sync[1] & sck_sync[2];
    assign cs_rise  = cs_sync[1] & ~cs_sync[2];
    assign cs_fall  = ~cs_sync[1] & cs_sync[2];
    assign busy     = ~cs_sync[1];

    assign bit_next  = bit_cnt + 3'd1;
    assign byte_next = (bit_cnt != 3'd7) ? byte_cnt :
                       (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + BYTE_W'(1);
    assign word_end  = (bit_cnt == 3'd7) && (byte_cnt == LAST_BYTE);

    assign rx_word_done = (state == RX_FRAME) && !cs_rise && sck_rise && word_end;
    assign tx_word_end  = (state == TX_FRAME) && !cs_rise && sck_fall && word_end;
    assign tx_enter     = (state == IDLE) && cs_fall && rw;
    assign reload       = tx_enter || tx_word_end;
    assign tx_capture   = tx_valid && !hold_full;
    assign reload_word  = hold_full ? hold_data : '0;

    assign tx_ready = ~hold_full;
    assign intr     = hold_full;

    // A capture can only happen into an empty holding register, so a reload in the
    // same cycle has already taken the old (empty) content and zero is shifted out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (tx_capture) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
        end else if (reload) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            byte_cnt <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            miso     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (cs_rise) begin
                state    <= IDLE;
                bit_cnt  <= 3'd0;
                byte_cnt <= '0;
                miso     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            bit_cnt  <= 3'd0;
                            byte_cnt <= '0;
                            if (rw) begin
                                state    <= TX_FRAME;
                                tx_shift <= reload_word;
                                miso     <= reload_word[BUS_WIDTH-1];
                            end else begin
                                state <= RX_FRAME;
                            end
                        end
                    end
                    RX_FRAME: begin
                        if (sck_rise) begin
                            rx_shift <= {rx_shift[BUS_WIDTH-3:0], mosi_bit};
                            bit_cnt  <= bit_next;
                            byte_cnt <= byte_next;
                            // A word finishing while the previous one is still held is dropped.
                            if (rx_word_done && !rx_valid) begin
                                rx_data  <= {rx_shift, mosi_bit};
                                rx_valid <= 1'b1;
                            end
                        end
                    end
                    TX_FRAME: begin
                        if (sck_fall) begin
                            bit_cnt  <= bit_next;
                            byte_cnt <= byte_next;
                            if (word_end) begin
                                tx_shift <= reload_word;
                                miso     <= reload_word[BUS_WIDTH-1];
                            end else begin
                                tx_shift <= tx_shift << 1;
                                miso     <= tx_shift[BUS_WIDTH-2];
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (rx_word_done && rx_valid) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_word_slave.sv
// Directed bench for spi_word_slave: SPI master driver plus a word-level model of the slave.
`timescale 1ns/1ps
module tb_spi_word_slave;
    localparam int BW   = 32;
    localparam int HALF = 5;
`ifdef SPI_SLAVE_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          sck      = 1'b0;
    logic          cs       = 1'b1;
    logic          mosi     = 1'b0;
    logic          rw       = 1'b0;
    logic          rx_ready = 1'b0;
    logic          tx_valid = 1'b0;
    logic [BW-1:0] tx_data  = '0;
    logic          miso;
    logic          intr;
    logic          rx_valid;
    logic          tx_ready;
    logic          busy;
    logic          overrun;
    logic [BW-1:0] rx_data;

    spi_word_slave #(.BUS_WIDTH(BW), .WORD_SIZE_BY(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .sck      (sck),
        .cs       (cs),
        .mosi     (mosi),
        .miso     (miso),
        .rw       (rw),
        .intr     (intr),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    int            n_compared   = 0;
    int            n_mismatched = 0;

    // Word-level model of the slave.
    logic [BW-1:0] frame_words[$];
    logic [BW-1:0] rx_expect_q[$];
    bit            miso_expect_q[$];
    bit            model_rx_held   = 1'b0;
    bit            model_overrun   = 1'b0;
    bit            model_hold_full = 1'b0;
    logic [BW-1:0] model_hold_data = '0;
    bit            tx_active       = 1'b0;

    // Observations collected by the compare process.
    logic [BW-1:0] cur_word      = '0;
    logic [BW-1:0] last_rx_data  = '0;
    logic [BW-1:0] miso_capture  = '0;
    int            rx_deliveries = 0;
    int            valid_cycles  = 0;
    bit            prev_valid    = 1'b0;
    bit            prev_ready    = 1'b0;
    bit            prev_sck      = 1'b0;

    task automatic check_output(input string name, input logic [BW-1:0] actual, input logic [BW-1:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic report_fail(input string name);
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: event seen, none expected", name);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_rx_word_done(input logic [BW-1:0] w);
        if (model_rx_held) begin
            model_overrun = model_overrun | OVR_EN;
        end else begin
            rx_expect_q.push_back(w);
            model_rx_held = 1'b1;
        end
    endtask

    task automatic model_reload(input bit push);
        logic [BW-1:0] w;
        w = model_hold_full ? model_hold_data : '0;
        model_hold_full = 1'b0;
        if (push) begin
            for (int k = BW - 1; k >= 0; k--) miso_expect_q.push_back(w[k]);
        end
    endtask

    task automatic load_tx(input logic [BW-1:0] d);
        check_output("tx_ready_before_load", tx_ready, !model_hold_full);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_clks(1);
        tx_valid = 1'b0;
        model_hold_full = 1'b1;
        model_hold_data = d;
        check_output("intr_after_load", intr, 1'b1);
        check_output("tx_ready_after_load", tx_ready, 1'b0);
    endtask

    // One SPI mode-0 frame of nbits, MSB first, bits taken from frame_words.
    task automatic apply_stimulus(input logic dir, input int nbits, input bit end_frame);
        logic [BW-1:0] w;
        rw = dir;
        if (dir) begin
            model_reload(1'b1);
            tx_active = 1'b1;
        end
        cs = 1'b0;
        wait_clks(2 * HALF);
        check_output("busy_in_frame", busy, 1'b1);
        check_output("intr_frame_start", intr, model_hold_full);
        for (int i = 0; i < nbits; i++) begin
            w = frame_words[i / BW];
            if (!dir && (i % BW) == BW - 1) model_rx_word_done(w);
            mosi = w[BW - 1 - (i % BW)];
            wait_clks(HALF);
            sck = 1'b1;
            wait_clks(HALF);
            sck = 1'b0;
            if (dir && (i % BW) == BW - 1) model_reload(i + 1 < nbits);
        end
        tx_active = 1'b0;
        if (end_frame) begin
            wait_clks(HALF);
            cs = 1'b1;
            wait_clks(2 * HALF);
            check_output("busy_after_frame", busy, 1'b0);
            check_output("rx_pending", 32'(rx_expect_q.size()), 32'd0);
            check_output("miso_pending", 32'(miso_expect_q.size()), 32'd0);
        end
    endtask

    // Single compare process: receive handshake every cycle, miso at each master sampling edge.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_sck   = 1'b0;
        end else begin
            if (rx_valid) valid_cycles++;
            if (rx_valid && !prev_valid) begin
                rx_deliveries++;
                last_rx_data = rx_data;
                if (rx_expect_q.size() == 0) begin
                    check_output("rx_valid_unexpected", rx_valid, 1'b0);
                end else begin
                    cur_word = rx_expect_q.pop_front();
                    check_output("rx_data_deliver", rx_data, cur_word);
                end
            end else if (rx_valid) begin
                check_output("rx_data_hold", rx_data, cur_word);
            end
            if (prev_valid && prev_ready) check_output("rx_valid_clear", rx_valid, 1'b0);
            if (rx_valid && rx_ready) model_rx_held = 1'b0;
            if (tx_active && sck && !prev_sck) begin
                miso_capture = {miso_capture[BW-2:0], miso};
                if (miso_expect_q.size() == 0) report_fail("miso_extra_bit");
                else check_output("miso_bit", miso, miso_expect_q.pop_front());
            end
            prev_valid = rx_valid;
            prev_ready = rx_ready;
            prev_sck   = sck;
        end
    end

    task automatic check_reset_values(input string tag);
        check_output({tag, "_miso"}, miso, 1'b0);
        check_output({tag, "_intr"}, intr, 1'b0);
        check_output({tag, "_rx_valid"}, rx_valid, 1'b0);
        check_output({tag, "_rx_data"}, rx_data, 32'h0);
        check_output({tag, "_tx_ready"}, tx_ready, 1'b1);
        check_output({tag, "_busy"}, busy, 1'b0);
        check_output({tag, "_overrun"}, overrun, 1'b0);
    endtask

    initial begin
        wait_clks(3);
        check_reset_values("reset");
        reset = 1'b0;
        wait_clks(3);

        // Plain write of one word with the controller always ready.
        rx_ready = 1'b1;
        frame_words.delete();
        frame_words.push_back(32'hDEADBEEF);
        rx_deliveries = 0;
        valid_cycles  = 0;
        apply_stimulus(1'b0, 32, 1'b1);
        check_output("t1_word", last_rx_data, 32'hDEADBEEF);
        check_output("t1_deliveries", 32'(rx_deliveries), 32'd1);
        check_output("t1_valid_cycles", 32'(valid_cycles), 32'd1);

        // Read of a preloaded word; mosi toggles are ignored.
        load_tx(32'h12345678);
        frame_words.delete();
        frame_words.push_back(32'hFFFFFFFF);
        miso_capture  = '0;
        rx_deliveries = 0;
        apply_stimulus(1'b1, 32, 1'b1);
        check_output("t2_miso_word", miso_capture, 32'h12345678);
        check_output("t2_intr_after", intr, 1'b0);
        check_output("t2_no_rx", 32'(rx_deliveries), 32'd0);
        check_output("t2_miso_idle", miso, 1'b0);

        // Two words while the controller is stalled: the second is dropped.
        rx_ready = 1'b0;
        frame_words.delete();
        frame_words.push_back(32'h00000001);
        frame_words.push_back(32'h00000002);
        rx_deliveries = 0;
        apply_stimulus(1'b0, 64, 1'b1);
        check_output("t3_rx_valid_held", rx_valid, 1'b1);
        check_output("t3_rx_data_held", rx_data, 32'h00000001);
        check_output("t3_deliveries", 32'(rx_deliveries), 32'd1);
        check_output("t3_overrun_model", overrun, model_overrun);
        check_output("t3_overrun_literal", overrun, OVR_EN);
        rx_ready = 1'b1;
        wait_clks(3);
        check_output("t3_rx_valid_released", rx_valid, 1'b0);

        // Aborted partial word followed by a complete one.
        frame_words.delete();
        frame_words.push_back(32'hFFFFFFFF);
        rx_deliveries = 0;
        apply_stimulus(1'b0, 12, 1'b1);
        frame_words.delete();
        frame_words.push_back(32'hA5A5A5A5);
        apply_stimulus(1'b0, 32, 1'b1);
        check_output("t4_deliveries", 32'(rx_deliveries), 32'd1);
        check_output("t4_word", last_rx_data, 32'hA5A5A5A5);

        // Read with nothing loaded shifts out zeros.
        frame_words.delete();
        frame_words.push_back(32'hFFFFFFFF);
        miso_capture = 32'hFFFFFFFF;
        apply_stimulus(1'b1, 32, 1'b1);
        check_output("t5_miso_word", miso_capture, 32'h0);
        check_output("t5_tx_ready", tx_ready, 1'b1);
        check_output("t5_intr", intr, 1'b0);

        // Reset in the middle of a write frame.
        frame_words.delete();
        frame_words.push_back(32'hCAFEF00D);
        apply_stimulus(1'b0, 20, 1'b0);
        reset = 1'b1;
        #1;
        check_reset_values("midrx_reset");
        model_rx_held = 1'b0;
        model_overrun = 1'b0;
        rx_expect_q.delete();
        cs = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        rx_deliveries = 0;
        wait_clks(50);
        check_output("t6_no_delivery", 32'(rx_deliveries), 32'd0);
        check_output("t6_rx_valid", rx_valid, 1'b0);
        check_output("t6_rx_data", rx_data, 32'h0);
        check_output("t6_overrun", overrun, model_overrun);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/spi_word_slave.md
SPI_WORD_SLAVE -- requirements
Module: spi_word_slave

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter WORD_SIZE_BY, default 4, bytes per word; BUS_WIDTH = 8*WORD_SIZE_BY.
REQ-003 SHALL have clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have sck  input  1  SPI clock from master, asynchronous to clk.
REQ-006 SHALL have cs  input  1  SPI chip select, active-low, asynchronous.
REQ-007 SHALL have mosi  input  1  master-to-slave serial data.
REQ-008 SHALL have miso  output  1  slave-to-master serial data.
REQ-009 SHALL have rw  input  1  frame direction: 0 = master writes, 1 = master reads.
REQ-010 SHALL have intr  output  1  high while a transmit word is pending for the master.
REQ-011 SHALL have rx_data  output  BUS_WIDTH  received word toward controller.
REQ-012 SHALL have rx_valid / rx_ready  output / input  1 each  receive handshake.
REQ-013 SHALL have tx_data  input  BUS_WIDTH  word to send to master.
REQ-014 SHALL have tx_valid / tx_ready  input / output  1 each  transmit handshake.
REQ-015 SHALL have busy  output  1  high while synchronized cs is low.
REQ-016 SHALL have overrun  output  1  sticky receive-overrun flag.

Function
REQ-017 SHALL synchronize sck, cs, mosi through 2 flops; edges detected from a third sck/cs flop.
REQ-018 SHALL support SPI mode 0, MSB first, sck up to clk/8.
REQ-019 SHALL have states IDLE (cs high), RX_FRAME, TX_FRAME; IDLE -> RX_FRAME or TX_FRAME on synchronized cs falling edge per rw sampled that cycle; any state -> IDLE on cs rising edge.
REQ-020 SHALL, in RX_FRAME, sample mosi on each synchronized sck rising edge; 3-bit bit counter, byte counter 0..WORD_SIZE_BY-1, both wrap.
REQ-021 SHALL pack bytes big-endian: first byte of a word lands in rx_data[BUS_WIDTH-1 -: 8].
REQ-022 SHALL load rx_data and set rx_valid one clk after the edge completing the last bit of a word.
REQ-023 SHALL hold rx_data/rx_valid stable until rx_valid && rx_ready; rx_valid clears the following cycle.
REQ-024 SHALL, if a word completes while rx_valid is high, drop the new word and keep the held word.
REQ-025 SHALL discard a partial word when cs rises mid-word; counters return to 0.
REQ-026 SHALL hold one transmit word: tx_ready = holding empty; capture on tx_valid && tx_ready; intr = holding full.
REQ-027 SHALL, on entering TX_FRAME, move holding into shift register (holding emptied) or load zero if empty, and drive its MSB on miso.
REQ-028 SHALL shift miso on each synchronized sck falling edge; at each word boundary reload from holding as in REQ-027.
REQ-029 SHALL ignore mosi in TX_FRAME and drive miso 0 in IDLE and RX_FRAME.
REQ-030 SHALL give tx capture priority over reload in the same cycle only if holding was empty; reload takes the prior content.

Reset
REQ-031 SHALL on reset: state IDLE, counters 0, miso 0, intr 0, rx_valid 0, rx_data 0, tx_ready 1, busy 0, overrun 0, holding empty, sync flops cs=1 sck=0.
REQ-032 SHALL abort any frame on reset; no partial word emitted after release.

Configuration
REQ-033 SHALL, with SPI_SLAVE_OVERRUN_EN defined, set overrun on each REQ-024 drop, cleared only by reset.
REQ-034 SHALL, without SPI_SLAVE_OVERRUN_EN, tie overrun to 0 and omit its flop; drop behaviour unchanged.

Verification
REQ-035 SHALL test rw=0, 32 sck bits 0xDEADBEEF, rx_ready=1 -> rx_data=0xDEADBEEF, rx_valid one cycle.
REQ-036 SHALL test tx_data=0x12345678 loaded, rw=1 frame of 32 sck -> miso bits 0x12345678, intr 1->0 at frame start.
REQ-037 SHALL test rx_ready=0, two words 0x00000001 then 0x00000002 -> rx_data stays 0x00000001, overrun=1 (macro on) / 0 (off).
REQ-038 SHALL test cs rise after 12 bits, then full word 0xA5A5A5A5 -> only 0xA5A5A5A5 delivered.
REQ-039 SHALL test rw=1 with empty holding -> miso all 0, tx_ready stays 1.
REQ-040 SHALL test reset asserted mid-RX after 20 bits -> all outputs at REQ-031 values same cycle, no rx_valid afterwards.
